// File: rtl/spi_slave.sv
// SPI slave, all four modes, LSB first, DATA_WIDTH-bit words.
// SCLK/SS/MOSI are resynchronised into clk; all protocol logic runs on clk.
module spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  SCLK,
  input  logic                  SS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] snd_data,
  output logic [DATA_WIDTH-1:0] rcv_data,
  output logic                  done,
  output logic                  busy,
  output logic                  abort
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // [0],[1] synchroniser stages, [2] history for edge detection
  logic [2:0] sclk_q, ss_q, mosi_q;
  logic [1:0] vld_q;
  logic       armed_q;

  logic [0:0]            state_q, state_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d, tx_q, tx_d, rcv_q, rcv_d;
  logic                  miso_q, miso_d, done_q, done_d, abort_q, abort_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q  <= '0;
      ss_q    <= '1;
      mosi_q  <= '0;
      vld_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      sclk_q  <= {sclk_q[1:0], SCLK};
      ss_q    <= {ss_q[1:0], SS};
      mosi_q  <= {mosi_q[1:0], MOSI};
      vld_q   <= {vld_q[0], 1'b1};
      // A start needs SS genuinely seen high since reset, so SS held low
      // through reset release is not mistaken for a fresh select.
      armed_q <= armed_q | (vld_q[1] & ss_q[1]);
    end
  end

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic lead_edge, trail_edge, full, active, sample_edge, shift_edge, last_sample;

  assign ss_fall     = ss_q[2] & ~ss_q[1];
  assign ss_rise     = ~ss_q[2] & ss_q[1];
  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign full        = (cnt_q == CW'(DATA_WIDTH));
  assign active      = (state_q == ST_ACTIVE) & ~full;
  assign sample_edge = active & (cpha_q ? trail_edge : lead_edge);
  assign shift_edge  = active & (cpha_q ? lead_edge : trail_edge);
  assign last_sample = sample_edge & (cnt_q == CW'(DATA_WIDTH - 1));

  always_comb begin
    // NOTE: every always_comb output is defaulted first so no latch is inferred.
    state_d = state_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    rcv_d   = rcv_q;
    miso_d  = miso_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (armed_q && ss_fall) begin
          state_d = ST_ACTIVE;
          cpol_d  = mode[1];
          cpha_d  = mode[0];
          cnt_d   = '0;
          rx_d    = '0;
          if (mode[0]) begin
            tx_d = snd_data;
          end else begin
            miso_d = snd_data[0];
            tx_d   = {1'b0, snd_data[DATA_WIDTH-1:1]};
          end
        end
      end
      default: begin
        if (shift_edge) begin
          miso_d = tx_q[0];
          tx_d   = {1'b0, tx_q[DATA_WIDTH-1:1]};
        end
        if (sample_edge) begin
          rx_d  = {mosi_q[2], rx_q[DATA_WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
        end
        if (last_sample) begin
          rcv_d  = rx_d;
          done_d = 1'b1;
          miso_d = 1'b0;
        end
        if (ss_rise) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
          abort_d = ~full & ~last_sample;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      rcv_q   <= '0;
      miso_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      rcv_q   <= rcv_d;
      miso_q  <= miso_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign MISO     = miso_q;
  assign rcv_data = rcv_q;
  assign done     = done_q;
  assign abort    = abort_q;
  assign busy     = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed and random bench for spi_slave: a behavioural SPI master drives
// the slave and captures MISO; results are compared to hand-computed words.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       SCLK = 1'b0;
  logic       SS = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [7:0] snd_data = 8'h00;
  logic [7:0] rcv_data;
  logic       done, busy, abort;

  int n_cmp = 0;
  int n_bad = 0;
  int done_n = 0;
  int abort_n = 0;
  int ss_hi = 0;
  int miso_bad = 0;

  spi_slave #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .SCLK(SCLK), .SS(SS), .MOSI(MOSI),
    .MISO(MISO), .snd_data(snd_data), .rcv_data(rcv_data),
    .done(done), .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  // Pulse counters and idle-MISO watch, sampled away from the active edge.
  always @(negedge clk) begin
    if (done)  done_n++;
    if (abort) abort_n++;
    if (SS) ss_hi++; else ss_hi = 0;
    if (ss_hi >= 4 && MISO !== 1'b0) miso_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Master: LSB first; chg_bit >= 0 overwrites snd_data with 0xFF at that bit.
  task automatic xfer(input logic [1:0] m, input logic [7:0] mosi_w, input logic [7:0] snd_w,
                      input int nbits, input int half, input int chg_bit,
                      input bit raise, input int gap, output logic [7:0] cap);
    cap = 8'h00;
    mode = m;
    snd_data = snd_w;
    SCLK = m[1];
    MOSI = m[0] ? 1'b0 : mosi_w[0];
    @(negedge clk);
    SS = 1'b0;
    repeat (half) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      if (k == chg_bit) snd_data = 8'hFF;
      if (!m[0]) begin
        cap[k] = MISO;
        SCLK = ~SCLK;
        repeat (half) @(negedge clk);
        SCLK = ~SCLK;
        MOSI = mosi_w[(k + 1) % 8];
        repeat (half) @(negedge clk);
      end else begin
        SCLK = ~SCLK;
        MOSI = mosi_w[k];
        repeat (half) @(negedge clk);
        cap[k] = MISO;
        SCLK = ~SCLK;
        repeat (half) @(negedge clk);
      end
    end
    if (raise) begin
      SS = 1'b1;
      repeat (gap) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] cap, w_tx, w_snd;
    logic [1:0] m;
    int d0, a0;

    repeat (3) @(negedge clk);
    check("rst_miso",  MISO, 0);
    check("rst_rcv",   rcv_data, 0);
    check("rst_done",  done, 0);
    check("rst_busy",  busy, 0);
    check("rst_abort", abort, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Mode 0: 0xA5 in, 0x3C out; busy checked before and after SS rise
    d0 = done_n; a0 = abort_n;
    xfer(2'd0, 8'hA5, 8'h3C, 8, 5, -1, 1'b0, 0, cap);
    check("m0_busy_hi", busy, 1);
    SS = 1'b1;
    repeat (10) @(negedge clk);
    check("m0_rcv",   rcv_data, 8'hA5);
    check("m0_cap",   cap, 8'h3C);
    check("m0_done",  done_n - d0, 1);
    check("m0_abort", abort_n - a0, 0);
    check("m0_busy_lo", busy, 0);

    // Mode 3 and mode 1
    xfer(2'd3, 8'h5A, 8'hC3, 8, 5, -1, 1'b1, 10, cap);
    check("m3_rcv",  rcv_data, 8'h5A);
    check("m3_cap",  cap, 8'hC3);
    check("m3_busy", busy, 0);
    xfer(2'd1, 8'h5A, 8'hC3, 8, 5, -1, 1'b1, 10, cap);
    check("m1_rcv",  rcv_data, 8'h5A);
    check("m1_cap",  cap, 8'hC3);
    check("m1_busy", busy, 0);

    // Mode 2 with snd_data overwritten mid-transfer
    xfer(2'd2, 8'hA5, 8'h81, 8, 5, 3, 1'b1, 10, cap);
    check("m2_rcv", rcv_data, 8'hA5);
    check("m2_cap", cap, 8'h81);

    // Early SS rise after 5 bits
    d0 = done_n; a0 = abort_n;
    xfer(2'd0, 8'h33, 8'h00, 5, 5, -1, 1'b1, 10, cap);
    check("ab_abort", abort_n - a0, 1);
    check("ab_done",  done_n - d0, 0);
    check("ab_rcv",   rcv_data, 8'hA5);

    // Reset mid-transfer, SS still low at release
    d0 = done_n; a0 = abort_n;
    xfer(2'd0, 8'h77, 8'h00, 3, 5, -1, 1'b0, 0, cap);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("rm_busy", busy, 0);
    SS = 1'b1;
    repeat (6) @(negedge clk);
    check("rm_done",  done_n - d0, 0);
    check("rm_abort", abort_n - a0, 0);
    check("rm_rcv0",  rcv_data, 0);
    xfer(2'd0, 8'h12, 8'h9E, 8, 5, -1, 1'b1, 10, cap);
    check("rm_rcv",  rcv_data, 8'h12);
    check("rm_cap",  cap, 8'h9E);
    check("rm_done2", done_n - d0, 1);

    // Random back-to-back transfers, 3-cycle SS gap, minimum SCLK half-period
    d0 = done_n; a0 = abort_n; miso_bad = 0;
    for (int i = 0; i < 400; i++) begin
      m = 2'($urandom_range(0, 3));
      w_tx = 8'($urandom);
      w_snd = 8'($urandom);
      xfer(m, w_tx, w_snd, 8, 4, -1, 1'b1, 2, cap);
      check("rnd_rcv", rcv_data, w_tx);
      check("rnd_cap", cap, w_snd);
    end
    repeat (10) @(negedge clk);
    check("rnd_done",  done_n - d0, 400);
    check("rnd_abort", abort_n - a0, 0);
    check("rnd_miso_idle", miso_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
